// File: rtl/sub_share_ctrl_pkg.sv
// Shared types for the sub datapath sharing controller.
// Provides requester tag type, tag pipeline stage payload and the
// round-robin pointer advance helper.
package sub_ctrl_pkg;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned NREQ_MAX   = 8;
  localparam int unsigned TAG_W      = $clog2(NREQ_MAX);

  typedef logic [TAG_W-1:0] tag_t;

  // One tag pipeline stage: valid flag plus owning requester id.
  typedef struct packed {
    logic v;
    tag_t id;
  } tag_stage_t;

  // Round-robin successor of id, wrapping at nreq.
  function automatic tag_t rr_next(input tag_t id, input int unsigned nreq);
    return ((32'(id) + 32'd1) >= nreq) ? tag_t'(0) : id + tag_t'(1);
  endfunction

endpackage

// File: rtl/sub_share_ctrl_if.sv
// Bundle of requester, response and datapath signals around sub_share_ctrl.
// slave  : controller side (drives req_ready, rsp_*, dp_in/dp_valid, busy)
// master : client/datapath side (drives req_*, rsp_ready, dp_out)
interface sub_share_ctrl_if
  import sub_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = DW_DEFAULT
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ*DW-1:0] rsp_data;
  logic [NREQ-1:0]    rsp_ready;
  logic [DW-1:0]      dp_in;
  logic               dp_valid;
  logic [DW-1:0]      dp_out;
  logic               busy;

  modport slave (
    input  req_valid, req_data, rsp_ready, dp_out,
    output req_ready, rsp_valid, rsp_data, dp_in, dp_valid, busy
  );

  modport master (
    output req_valid, req_data, rsp_ready, dp_out,
    input  req_ready, rsp_valid, rsp_data, dp_in, dp_valid, busy
  );

endinterface

// File: rtl/sub_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// eligible_i : per-requester eligibility
// rr_ptr_i   : highest-priority requester this cycle (owned by parent)
// grant_o    : one-hot grant, zero when nothing is eligible
// grant_id_o : index of the granted requester (0 when none)
module sub_rr_arbiter
  import sub_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] eligible_i,
  input  tag_t            rr_ptr_i,
  output logic [NREQ-1:0] grant_o,
  output tag_t            grant_id_o
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic              found;
  int unsigned       idx;
  tag_t              gid;

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    dbl   = {eligible_i, eligible_i} >> rr_ptr_i;
    rot   = dbl[NREQ-1:0];
    found = 1'b0;
    idx   = 0;
    gid   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        idx   = 32'(rr_ptr_i) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        gid   = tag_t'(idx);
      end
    end
    grant_o = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (found && (gid == tag_t'(j))) grant_o[j] = 1'b1;
    end
    grant_id_o = gid;
  end

endmodule

// File: rtl/sub_share_ctrl.sv
// Time-shares one fixed-latency sub datapath between NREQ requesters.
// clk, reset : single clock, synchronous active-high reset
// bus.req_*  : per-requester request handshake (req_ready combinational)
// bus.rsp_*  : per-requester one-entry response registers
// bus.dp_*   : operand out to / result in from the shared datapath
// bus.busy   : some requester has a transaction outstanding
module sub_share_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = DW_DEFAULT,
  parameter int unsigned LAT  = 2
) (
  input logic            clk,
  input logic            reset,
  sub_share_ctrl_if.slave bus
);

  tag_t               rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]    pending_q, pending_d;
  logic [NREQ-1:0]    eligible, grant;
  tag_t               grant_id;
  logic               issue;
  logic [DW-1:0]      dp_in_q, dp_in_d;
  logic               dp_valid_q;
  tag_stage_t         tag_q [LAT+1];
  logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d, rsp_hs, cap;
  logic [NREQ*DW-1:0] rsp_data_q, rsp_data_d;

  // A requester with an outstanding transaction cannot be granted again.
  assign eligible = bus.req_valid & ~pending_q;
  assign issue    = |grant;
  assign rsp_hs   = rsp_valid_q & bus.rsp_ready;

  sub_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  // Stage LAT lines up with dp_out for the operand it tags.
  always_comb begin
    cap = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (tag_q[LAT].v && (tag_q[LAT].id == tag_t'(i))) cap[i] = 1'b1;
    end
  end

  // Next-state for pointer, operand register, pending and responses.
  always_comb begin
    rr_ptr_d = issue ? rr_next(grant_id, NREQ) : rr_ptr_q;
    dp_in_d  = dp_in_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) dp_in_d = bus.req_data[i*DW +: DW];
    end
    // Set and clear of the same bit cannot coincide: grant needs ~pending.
    pending_d   = (pending_q | grant) & ~rsp_hs;
    rsp_valid_d = (rsp_valid_q & ~rsp_hs) | cap;
    rsp_data_d  = rsp_data_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (cap[i]) rsp_data_d[i*DW +: DW] = bus.dp_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      pending_q   <= '0;
      dp_in_q     <= '0;
      dp_valid_q  <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int unsigned k = 0; k <= LAT; k++) tag_q[k] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      pending_q   <= pending_d;
      dp_in_q     <= dp_in_d;
      dp_valid_q  <= issue;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      tag_q[0]    <= tag_stage_t'{v: issue, id: grant_id};
      for (int unsigned k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // Structural invariants of the sharing scheme.
  always @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(grant));
      assert ((cap & rsp_valid_q) == '0);
      for (int unsigned k = 0; k <= LAT; k++) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (tag_q[k].v && (tag_q[k].id == tag_t'(i))) assert (pending_q[i]);
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.dp_in     = dp_in_q;
  assign bus.dp_valid  = dp_valid_q;
  assign bus.busy      = |pending_q;

endmodule

// File: tb/tb_sub_share_ctrl.sv
// Bench for sub_share_ctrl: directed scenarios plus random traffic, every
// cycle compared against a transaction-level model of the sharing rules.
module tb_sub_share_ctrl;
  import sub_ctrl_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sub_share_ctrl_if #(.NREQ(N), .DW(DW)) bus ();

  sub_share_ctrl #(.NREQ(N), .DW(DW), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stand-in datapath: dp_out = dp_in ^ dp_key, LAT cycles later.
  logic [DW-1:0] dp_key = '0;
  logic [DW-1:0] dpipe [LAT];
  always @(posedge clk) begin
    dpipe[0] <= bus.dp_in ^ dp_key;
    for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
  end
  assign bus.dp_out = dpipe[LAT-1];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state.
  typedef struct {
    int            id;
    logic [DW-1:0] val;
    int            due;
  } fl_t;
  fl_t           fq[$];
  int            m_ptr;
  bit            m_pend [N];
  bit            m_rv   [N];
  logic [DW-1:0] m_rd   [N];
  bit            m_dpv;
  logic [DW-1:0] m_dpd;
  logic [N-1:0]  obs_rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] rv);
    int i;
    for (int k = 0; k < int'(N); k++) begin
      i = (m_ptr + k) % int'(N);
      if (rv[i] && !m_pend[i]) return i;
    end
    return -1;
  endfunction

  function automatic int gid_of(input logic [N-1:0] oh);
    for (int i = 0; i < int'(N); i++) if (oh[i]) return i;
    return -1;
  endfunction

  // One clock cycle: drive, check grant, advance model, check registers.
  task automatic step(input bit rst, input logic [N-1:0] rv,
                      input logic [N*DW-1:0] rd, input logic [N-1:0] rr);
    int           g;
    logic [N-1:0] exp_rdy;
    fl_t          e;
    reset         = rst;
    bus.req_valid = rv;
    bus.req_data  = rd;
    bus.rsp_ready = rr;
    #1;
    g       = rst ? -1 : model_grant(rv);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    obs_rdy = bus.req_ready;
    if (!rst) check("req_ready", 64'(obs_rdy), 64'(exp_rdy));
    if (rst) begin
      m_ptr = 0;
      m_dpv = 1'b0;
      m_dpd = '0;
      fq.delete();
      for (int i = 0; i < int'(N); i++) begin
        m_pend[i] = 1'b0;
        m_rv[i]   = 1'b0;
        m_rd[i]   = '0;
      end
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (m_rv[i] && rr[i]) begin
          m_rv[i]   = 1'b0;
          m_pend[i] = 1'b0;
        end
      end
      if (g >= 0) begin
        m_pend[g] = 1'b1;
        m_ptr     = (g + 1) % int'(N);
        m_dpv     = 1'b1;
        m_dpd     = rd[g*DW +: DW];
        e.id      = g;
        e.val     = rd[g*DW +: DW] ^ dp_key;
        e.due     = cyc + 2 + int'(LAT);
        fq.push_back(e);
      end else begin
        m_dpv = 1'b0;
      end
      for (int j = fq.size() - 1; j >= 0; j--) begin
        if (fq[j].due == cyc + 1) begin
          m_rv[fq[j].id] = 1'b1;
          m_rd[fq[j].id] = fq[j].val;
          fq.delete(j);
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    check("dp_valid", 64'(bus.dp_valid), 64'(m_dpv));
    check("dp_in", 64'(bus.dp_in), 64'(m_dpd));
    check("busy", 64'(bus.busy), 64'((m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3])));
    for (int i = 0; i < int'(N); i++) begin
      check($sformatf("rsp_valid%0d", i), 64'(bus.rsp_valid[i]), 64'(m_rv[i]));
      check($sformatf("rsp_data%0d", i), 64'(bus.rsp_data[i*DW +: DW]), 64'(m_rd[i]));
    end
  endtask

  initial begin
    logic [N*DW-1:0] d;
    int              gcount [N];
    int              order[$];
    int              others;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = '0;
    d             = '0;

    // Reset state.
    step(1'b1, '0, '0, '0);
    step(1'b1, '0, '0, '0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_dp_valid", 64'(bus.dp_valid), 64'h0);

    // Single request, identity datapath.
    d       = '0;
    d[31:0] = 32'h0000_1234;
    step(1'b0, 4'b0001, d, 4'hF);
    check("single_grant", 64'(obs_rdy), 64'h1);
    check("single_dp_valid", 64'(bus.dp_valid), 64'h1);
    check("single_dp_in", 64'(bus.dp_in), 64'h1234);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0000, d, 4'hF);
    check("single_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("single_rsp_data", 64'(bus.rsp_data[31:0]), 64'h1234);
    step(1'b0, 4'b0000, d, 4'hF);
    check("single_busy_drop", 64'(bus.busy), 64'h0);

    // All four requesting continuously.
    step(1'b1, '0, '0, '0);
    for (int i = 0; i < int'(N); i++) gcount[i] = 0;
    for (int c = 0; c < 12; c++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      step(1'b0, 4'hF, d, 4'hF);
      order.push_back(gid_of(obs_rdy));
      if (gid_of(obs_rdy) >= 0) gcount[gid_of(obs_rdy)]++;
    end
    for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), 64'(order[i]), 64'(i));
    check("rr_gap_after_round", 64'(order[4]), 64'(-1));
    for (int i = 0; i < int'(N); i++)
      check($sformatf("no_starve%0d", i), 64'(gcount[i] >= 2), 64'h1);

    // Backpressure on requester 1.
    step(1'b1, '0, '0, '0);
    d        = {$urandom, $urandom, $urandom, $urandom};
    d[63:32] = 32'hBEEF_0001;
    step(1'b0, 4'b0010, d, 4'b1101);
    check("bp_grant1", 64'(obs_rdy), 64'h2);
    others = 0;
    for (int c = 0; c < 11; c++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      step(1'b0, 4'b1101, d, 4'b1101);
      if (obs_rdy != 4'b0000 && obs_rdy != 4'b0010) others++;
    end
    check("bp_hold_valid", 64'(bus.rsp_valid[1]), 64'h1);
    check("bp_hold_data", 64'(bus.rsp_data[63:32]), 64'hBEEF_0001);
    check("bp_others_issue", 64'(others >= 6), 64'h1);
    step(1'b0, 4'b0010, d, 4'hF);
    check("bp_release_same_cycle", 64'(obs_rdy), 64'h0);
    step(1'b0, 4'b0010, d, 4'hF);
    check("bp_regrant", 64'(obs_rdy), 64'h2);

    // Same-cycle response accept and new request on requester 2.
    step(1'b1, '0, '0, '0);
    d = {$urandom, $urandom, $urandom, $urandom};
    step(1'b0, 4'b0100, d, 4'hF);
    check("sc_grant2", 64'(obs_rdy), 64'h4);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0100, d, 4'hF);
    check("sc_rsp_valid2", 64'(bus.rsp_valid), 64'h4);
    step(1'b0, 4'b0100, d, 4'hF);
    check("sc_no_grant", 64'(obs_rdy), 64'h0);
    step(1'b0, 4'b0100, d, 4'hF);
    check("sc_grant_next", 64'(obs_rdy), 64'h4);

    // Reset in the middle of two transactions.
    step(1'b1, '0, '0, '0);
    d = {$urandom, $urandom, $urandom, $urandom};
    step(1'b0, 4'b0011, d, 4'hF);
    step(1'b0, 4'b0010, d, 4'hF);
    step(1'b0, 4'b0000, d, 4'hF);
    step(1'b1, 4'b0000, d, 4'hF);
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("mid_rst_busy", 64'(bus.busy), 64'h0);
    check("mid_rst_dp_valid", 64'(bus.dp_valid), 64'h0);
    check("mid_rst_dp_in", 64'(bus.dp_in), 64'h0);
    check("mid_rst_rsp_data", 64'(bus.rsp_data == '0), 64'h1);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 4'b0000, d, 4'hF);
      check("no_late_capture", 64'(bus.rsp_valid), 64'h0);
    end
    d[127:96] = 32'hCAFE_0003;
    step(1'b0, 4'b1000, d, 4'hF);
    check("post_rst_grant", 64'(obs_rdy), 64'h8);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0000, d, 4'hF);
    check("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'h8);
    check("post_rst_rsp_data", 64'(bus.rsp_data[127:96]), 64'hCAFE_0003);

    // Round-robin wrap from pointer 3.
    step(1'b1, '0, '0, '0);
    d = {$urandom, $urandom, $urandom, $urandom};
    step(1'b0, 4'b0100, d, 4'hF);
    step(1'b0, 4'b1001, d, 4'hF);
    check("wrap_grant3", 64'(obs_rdy), 64'h8);
    step(1'b0, 4'b1001, d, 4'hF);
    check("wrap_grant0", 64'(obs_rdy), 64'h1);
    for (int c = 0; c < 6; c++) step(1'b0, 4'b0000, d, 4'hF);
    step(1'b0, 4'b1111, d, 4'hF);
    check("wrap_ptr_is_1", 64'(obs_rdy), 64'h2);

    // Random traffic with a non-identity datapath.
    step(1'b1, '0, '0, '0);
    dp_key = $urandom;
    for (int c = 0; c < 400; c++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 99) == 0), 4'($urandom), d,
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
